// File: rtl/uart_word_loader.sv
// uart_word_loader: receives UART bytes, packs them little-endian into RAM words, echoes them, and raises cpu_start on the end marker
module uart_word_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h10000,
  parameter logic [63:0] END_MARKER = 64'hDEADBEEF,
  parameter int ECHO_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              uart_tx,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wen,
  output logic              cpu_start,
  output logic              frame_err,
  output logic [15:0]       word_count
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int NB = DATA_W / 8;
  localparam int BW = $clog2(NB) + 1;
  localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NB - 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(NB);
  localparam logic [DATA_W-1:0] END_W = END_MARKER[DATA_W-1:0];

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t r_st, t_st;
  logic rx_m, rx_s;
  logic [CW-1:0] r_cnt, t_cnt;
  logic [2:0] r_bit, t_bit;
  logic [7:0] r_sh, t_sh, hold, echo_byte;
  logic hold_v, echo_stb, tx_r;
  logic [BW-1:0] b_idx;
  logic [DATA_W-1:0] word, word_nxt;
  logic [DATA_W+7:0] cat;
  logic [ADDR_W-1:0] load_addr;
  logic r_end, t_end, t_go, w_last;

  assign cat = {r_sh, word};
  assign word_nxt = cat[DATA_W+7:8];
  assign w_last = b_idx == B_LAST;
  assign r_end = r_cnt == C_FULL;
  assign t_end = t_cnt == C_FULL;
  assign t_go = (t_st == IDLE || (t_st == STOP && t_end)) && (hold_v || echo_stb);
  assign uart_tx = ECHO_EN != 0 ? tx_r : 1'b1;

  always_ff @(posedge clk or posedge rst)
    if (rst) {rx_m, rx_s} <= 2'b11;
    else {rx_m, rx_s} <= {uart_rx, rx_m};

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_st <= IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      r_sh <= '0;
      word <= '0;
      b_idx <= '0;
      load_addr <= BASE_ADDR;
      ram_addr <= BASE_ADDR;
      ram_wdata <= '0;
      ram_wen <= 1'b0;
      cpu_start <= 1'b0;
      frame_err <= 1'b0;
      word_count <= '0;
      echo_stb <= 1'b0;
      echo_byte <= '0;
    end else begin
      ram_wen <= 1'b0;
      frame_err <= 1'b0;
      echo_stb <= 1'b0;
      case (r_st)
        IDLE: begin
          r_cnt <= '0;
          if (!rx_s && !cpu_start) r_st <= START;
        end
        START: begin
          r_cnt <= r_cnt == C_HALF ? '0 : r_cnt + 1'b1;
          r_bit <= '0;
          if (r_cnt == C_HALF) r_st <= rx_s ? IDLE : DATA;
        end
        DATA: begin
          r_cnt <= r_end ? '0 : r_cnt + 1'b1;
          if (r_end) begin
            r_sh <= {rx_s, r_sh[7:1]};
            r_bit <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_st <= STOP;
          end
        end
        STOP: begin
          r_cnt <= r_end ? '0 : r_cnt + 1'b1;
          if (r_end) begin
            r_st <= IDLE;
            if (!rx_s) begin
              frame_err <= 1'b1;
              b_idx <= '0;
            end else begin
              echo_stb <= ECHO_EN != 0;
              echo_byte <= r_sh;
              word <= word_nxt;
              b_idx <= w_last ? '0 : b_idx + 1'b1;
              if (w_last && word_nxt == END_W) cpu_start <= 1'b1;
              if (w_last && word_nxt != END_W) begin
                ram_wen <= 1'b1;
                ram_addr <= load_addr;
                ram_wdata <= word_nxt;
                load_addr <= load_addr + STEP;
                word_count <= &word_count ? word_count : word_count + 16'd1;
              end
            end
          end
        end
        default: r_st <= IDLE;
      endcase
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      t_st <= IDLE;
      t_cnt <= '0;
      t_bit <= '0;
      t_sh <= '0;
      hold <= '0;
      hold_v <= 1'b0;
      tx_r <= 1'b1;
    end else begin
      hold_v <= t_go ? hold_v && echo_stb : hold_v || echo_stb;
      if (echo_stb && (t_go || !hold_v)) hold <= echo_byte;
      if (t_go) begin
        t_st <= START;
        t_cnt <= '0;
        t_sh <= hold_v ? hold : echo_byte;
        tx_r <= 1'b0;
      end else begin
        case (t_st)
          IDLE: tx_r <= 1'b1;
          START: begin
            t_cnt <= t_end ? '0 : t_cnt + 1'b1;
            if (t_end) begin
              t_st <= DATA;
              t_bit <= '0;
              tx_r <= t_sh[0];
            end
          end
          DATA: begin
            t_cnt <= t_end ? '0 : t_cnt + 1'b1;
            if (t_end) begin
              t_st <= t_bit == 3'd7 ? STOP : DATA;
              t_bit <= t_bit + 1'b1;
              t_sh <= t_sh >> 1;
              tx_r <= t_bit == 3'd7 ? 1'b1 : t_sh[1];
            end
          end
          STOP: begin
            t_cnt <= t_end ? '0 : t_cnt + 1'b1;
            if (t_end) t_st <= IDLE;
          end
          default: t_st <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_uart_word_loader.sv
// tb_uart_word_loader: directed UART stimulus against a byte-level model of the word loader
module tb_uart_word_loader;
  localparam int CPB = 8;

  logic clk = 1'b0, rst = 1'b1, uart_rx = 1'b1;
  logic tx1, wen1, cpu1, fe1, tx2, wen2, cpu2, fe2;
  logic [31:0] a1, d1, d2;
  logic [16:0] a2;
  logic [15:0] wc1, wc2;

  uart_word_loader #(.CLKS_PER_BIT(CPB), .DATA_W(32)) u1 (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(tx1), .ram_addr(a1), .ram_wdata(d1),
    .ram_wen(wen1), .cpu_start(cpu1), .frame_err(fe1), .word_count(wc1));

  uart_word_loader #(.CLKS_PER_BIT(CPB), .DATA_W(32), .ADDR_W(17), .BASE_ADDR(17'h1FFFC), .ECHO_EN(0)) u2 (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(tx2), .ram_addr(a2), .ram_wdata(d2),
    .ram_wen(wen2), .cpu_start(cpu2), .frame_err(fe2), .word_count(wc2));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [31:0] qa1[$], qd1[$], qd2[$];
  logic [16:0] qa2[$];
  logic [7:0] eq[$];
  logic [31:0] m_word, m_a1, last_a1, last_d1;
  logic [16:0] m_a2, last_a2;
  logic [7:0] last_echo;
  int m_parts, m_fe, m_cnt, epoch, fe_seen, wr1, wr2;
  bit m_cpu;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    qa1.delete(); qd1.delete(); qa2.delete(); qd2.delete(); eq.delete();
    m_word = 0; m_parts = 0; m_fe = 0; m_cnt = 0; m_cpu = 0;
    m_a1 = 32'h10000; m_a2 = 17'h1FFFC;
    fe_seen = 0; wr1 = 0; wr2 = 0;
    epoch++;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    if (m_cpu) return;
    if (!good) begin
      m_fe++;
      m_parts = 0;
      return;
    end
    eq.push_back(b);
    m_word[8*m_parts +: 8] = b;
    m_parts++;
    if (m_parts == 4) begin
      m_parts = 0;
      if (m_word == 32'hDEADBEEF) m_cpu = 1;
      else begin
        qa1.push_back(m_a1); qd1.push_back(m_word);
        qa2.push_back(m_a2); qd2.push_back(m_word);
        m_a1 += 4; m_a2 += 4; m_cnt++;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    model_byte(b, stop_ok);
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (stop_ok ? 4 : 16) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_tx", tx1, 1); chk("rst_wen", wen1, 0); chk("rst_cpu", cpu1, 0);
    chk("rst_fe", fe1, 0); chk("rst_addr", a1, 32'h10000); chk("rst_wdata", d1, 0);
    chk("rst_wc", wc1, 0); chk("rst_addr2", a2, 17'h1FFFC);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic checkpoint();
    chk("word_count", wc1, m_cnt); chk("word_count2", wc2, m_cnt);
    chk("cpu_start", cpu1, m_cpu); chk("cpu_start2", cpu2, m_cpu);
    chk("frame_errs", fe_seen, m_fe);
  endtask

  task automatic drain();
    repeat (100) @(negedge clk);
    chk("echo_pending", eq.size(), 0);
    chk("wr1_pending", qa1.size(), 0);
    chk("wr2_pending", qa2.size(), 0);
  endtask

  always @(negedge clk) if (!rst) begin
    if (wen1) begin
      wr1++; last_a1 = a1; last_d1 = d1;
      if (qa1.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr1_unexpected: got addr %0h data %0h expected no write", a1, d1);
      end else begin
        chk("wr1_addr", a1, qa1.pop_front());
        chk("wr1_data", d1, qd1.pop_front());
      end
    end
    if (wen2) begin
      wr2++; last_a2 = a2;
      if (qa2.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr2_unexpected: got addr %0h data %0h expected no write", a2, d2);
      end else begin
        chk("wr2_addr", a2, qa2.pop_front());
        chk("wr2_data", d2, qd2.pop_front());
      end
    end
    chk("tx2_idle", tx2, 1);
    if (fe1) fe_seen++;
  end

  initial forever begin
    @(negedge clk);
    if (!rst && tx1 === 1'b0) begin
      int ep;
      logic [7:0] b;
      ep = epoch;
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx1;
      end
      repeat (CPB) @(negedge clk);
      if (ep == epoch) begin
        chk("echo_stop", tx1, 1);
        if (eq.size() == 0) begin
          checks++; errors++;
          $display("FAIL echo_unexpected: got %0h expected none", b);
        end else begin
          chk("echo_byte", b, eq.pop_front());
          last_echo = b;
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    do_reset();
    send_word(32'h44332211);
    checkpoint();
    drain();
    chk("t1_addr", last_a1, 32'h10000); chk("t1_data", last_d1, 32'h44332211);
    chk("t1_wc", wc1, 1); chk("t1_echo", last_echo, 8'h44); chk("t1_addr2", last_a2, 17'h1FFFC);

    do_reset();
    send_word(32'h04030201);
    send_word(32'h08070605);
    send_word(32'hDEADBEEF);
    checkpoint();
    send_byte(8'h12);
    send_byte(8'h34);
    drain();
    checkpoint();
    chk("t2_writes", wr1, 2); chk("t2_addr", last_a1, 32'h10004); chk("t2_data", last_d1, 32'h08070605);
    chk("t2_wrap_addr2", last_a2, 17'h00000); chk("t2_cpu", cpu1, 1); chk("t2_echo", last_echo, 8'hDE);

    do_reset();
    send_byte(8'h55, 0);
    send_word(32'hDDCCBBAA);
    drain();
    checkpoint();
    chk("t3_fe", fe_seen, 1); chk("t3_addr", last_a1, 32'h10000); chk("t3_data", last_d1, 32'hDDCCBBAA);

    do_reset();
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    checkpoint();
    chk("t4_fe", fe_seen, 0); chk("t4_writes", wr1, 0);
    send_word(32'h0D0C0B0A);
    drain();
    chk("t4_data", last_d1, 32'h0D0C0B0A);

    do_reset();
    send_byte(8'h01);
    send_byte(8'h02);
    do_reset();
    send_word(32'h04030201);
    drain();
    checkpoint();
    chk("t5_addr", last_a1, 32'h10000); chk("t5_data", last_d1, 32'h04030201); chk("t5_wc", wc1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_word_loader.md
UART_WORD_LOADER -- requirements
Module: uart_word_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit; legal values are 4 or more.
REQ-002 Parameter DATA_W, default 32, meaning RAM word width; it is a multiple of 8 and lies in the range 8..64.
REQ-003 Parameter ADDR_W, default 32, meaning RAM address width.
REQ-004 Parameter BASE_ADDR, default 'h10000, meaning the first load address.
REQ-005 Parameter END_MARKER, default 'hDEADBEEF (zero-extended or truncated to DATA_W), meaning the terminating word.
REQ-006 Parameter ECHO_EN, default 1, meaning each received byte is echoed on uart_tx.
REQ-007 clk  input  1  single clock; all logic is on the rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 uart_rx  input  1  asynchronous serial input, 8N1, idle high.
REQ-010 uart_tx  output  1  serial echo output, 8N1, idle high.
REQ-011 ram_addr  output  ADDR_W  write address.
REQ-012 ram_wdata  output  DATA_W  write data.
REQ-013 ram_wen  output  1  one-cycle write strobe.
REQ-014 cpu_start  output  1  sticky load-complete flag.
REQ-015 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-016 word_count  output  16  number of words written; saturates at 'hFFFF.

Function
REQ-017 uart_rx SHALL pass through a 2-FF synchronizer before any use; the synchronizer resets to 1.
REQ-018 The RX FSM SHALL have these states and transitions:
- IDLE: go to START on synchronized rx = 0.
- START: wait CLKS_PER_BIT/2 cycles; if rx is still 0 go to DATA, else return to IDLE (glitch rejection).
- DATA: sample 8 bits LSB-first, each CLKS_PER_BIT cycles after the previous sample point.
- STOP: sample CLKS_PER_BIT cycles after the last data bit, then return to IDLE.
REQ-019 A stop sample of 1 SHALL complete a byte; a stop sample of 0 SHALL pulse frame_err for 1 cycle, discard the byte, and clear the partial-word byte counter.
REQ-020 Bytes SHALL assemble little-endian: the first byte goes to bits [7:0] and byte k goes to bits [8k+7:8k].
REQ-021 When byte DATA_W/8 of a word completes, and the word is not END_MARKER, the block SHALL, in the following cycle:
- drive ram_addr = load_addr and ram_wdata = the assembled word;
- assert ram_wen for exactly 1 cycle;
- advance load_addr by DATA_W/8 (modulo 2^ADDR_W, so it wraps);
- increment word_count (saturating).
REQ-022 A completed word equal to END_MARKER SHALL NOT be written; instead cpu_start SHALL rise in the following cycle and stay high until rst.
REQ-023 While cpu_start = 1, the block SHALL ignore uart_rx entirely: no writes, no echo, and no frame_err.
REQ-024 ram_addr and ram_wdata SHALL hold their last values when ram_wen = 0.
REQ-025 When ECHO_EN = 1, each good byte SHALL start transmitting within 2 cycles of stop-bit acceptance.
REQ-026 The TX FSM SHALL run IDLE -> START -> DATA (LSB first) -> STOP, holding each bit for CLKS_PER_BIT cycles, with a 1-byte holding register.
REQ-027 If a new echo byte arrives while both the TX shift register and the holding register are occupied, the newest byte SHALL be dropped from the echo only; the RAM write is unaffected.
REQ-028 When ECHO_EN = 0, uart_tx SHALL be constant 1.
REQ-029 The final byte of a word SHALL be handled together with its own write in the same cycle; no byte is lost across word boundaries.

Reset
REQ-030 While rst = 1, the block SHALL drive:
- uart_tx = 1, ram_wen = 0, cpu_start = 0, frame_err = 0;
- ram_addr = BASE_ADDR, ram_wdata = 0, word_count = 0.
REQ-031 While rst = 1, the internal state SHALL be: both FSMs in IDLE, load_addr = BASE_ADDR, byte counter = 0.
REQ-032 rst asserted mid-byte or mid-word SHALL discard all partial data; after release, the block SHALL wait for a fresh start edge.

Verification (CLKS_PER_BIT = 8, DATA_W = 32)
REQ-033 Send bytes 11 22 33 44 -> one ram_wen pulse with ram_addr = 'h10000 and ram_wdata = 'h44332211; word_count = 1; uart_tx echoes 11 22 33 44.
REQ-034 Send 2 words, then EF BE AD DE -> writes land at 'h10000 and 'h10004; no third write; cpu_start = 1; any later bytes cause no write and no echo.
REQ-035 Send byte 55 with stop bit = 0, then AA BB CC DD -> frame_err pulses once; the write is 'hDDCCBBAA at 'h10000.
REQ-036 Drive uart_rx low for 2 cycles, then high -> no byte completes; FSM returns to IDLE; no frame_err.
REQ-037 Assert rst after 2 bytes of a word, then send 01 02 03 04 -> write 'h04030201 at 'h10000.
REQ-038 With ADDR_W = 17 and BASE_ADDR = 'h1FFFC, send 2 words -> writes land at 'h1FFFC then 'h00000.
